// File: rtl/delay_search_ctrl.sv
// delay_search_ctrl
// Searches the taps of a programmable delay line for the best alignment.
// On a start request it steps the tap select through 0..L-1. For each tap it
// discards SETTLE qualified samples, then accumulates W = 2^LOG_W products of
// ref_dly*tgt_in. The tap with the largest signed sum wins; ties go to the
// lower tap. The delay line is left programmed to the winner. While idle, the
// tap select can also be loaded by hand.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   start             one-cycle search request (only honoured in IDLE)
//   man_load, man_sel manual tap load (only in IDLE, and only when start is low)
//   sample_en         marks ref_dly/tgt_in as a valid sample this cycle
//   ref_dly, tgt_in   signed 16-bit delayed reference sample and target sample
//   sel               tap select driven to the delay line
//   busy              high while a search is running
//   done              one-cycle pulse in the first IDLE cycle after a search
//   best_sel          winning tap of the last search
//   best_score        signed correlation of the winning tap
module delay_search_ctrl #(
    parameter int N      = 4,
    parameter int L      = 16,
    parameter int LOG_W  = 4,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  man_load,
    input  logic [N-1:0]          man_sel,
    input  logic                  sample_en,
    input  logic [15:0]           ref_dly,
    input  logic [15:0]           tgt_in,
    output logic [N-1:0]          sel,
    output logic                  busy,
    output logic                  done,
    output logic [N-1:0]          best_sel,
    output logic [32+LOG_W-1:0]   best_score
);

    localparam int AW = 32 + LOG_W;
    localparam int W  = 1 << LOG_W;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int CW = (LOG_W > SW) ? LOG_W : SW;

    localparam logic [CW-1:0] W_LAST   = CW'(W - 1);
    localparam logic [CW-1:0] S_LAST   = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [N-1:0]  SEL_LAST = N'(L - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ACCUM,
        ST_COMPARE,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [N-1:0]          sel_q, sel_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [N-1:0]          best_sel_q, best_sel_d;
    logic signed [AW-1:0]  best_score_q, best_score_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic signed [15:0]    ref_s;
    logic signed [15:0]    tgt_s;
    logic signed [31:0]    prod;

    // Both operands are sign-extended to 32 bits before multiplying. A 16x16
    // signed product always fits in 32 bits, so truncating to 32 bits loses
    // nothing, and summing W of them cannot overflow AW bits.
    assign ref_s = ref_dly;
    assign tgt_s = tgt_in;
    assign prod  = 32'(ref_s) * 32'(tgt_s);

    // State register. An asynchronous reset abandons any search in progress and
    // clears every result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            best_sel_q   <= '0;
            best_score_q <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            best_sel_q   <= best_sel_d;
            best_score_q <= best_score_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state logic. One counter is shared: SETTLE uses it to count discarded
    // samples and ACCUM uses it to count accumulated samples. It is cleared at
    // each hand-over between the two states.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        best_sel_d   = best_sel_q;
        best_score_d = best_score_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                    sel_d   = '0;
                    busy_d  = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (man_load) begin
                    sel_d = man_sel;
                end
            end

            ST_SETTLE: begin
                if (SETTLE == 0) begin
                    state_d = ST_ACCUM;
                end else if (sample_en) begin
                    if (cnt_q == S_LAST) begin
                        state_d = ST_ACCUM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            ST_ACCUM: begin
                if (sample_en) begin
                    acc_d = acc_q + AW'(prod);
                    if (cnt_q == W_LAST) begin
                        state_d = ST_COMPARE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            // Candidate 0 always seeds the best result. This gives a valid
            // winner even when every score is negative, and it discards the
            // result of the previous search.
            ST_COMPARE: begin
                if (sel_q == '0 || acc_q > best_score_q) begin
                    best_score_d = acc_q;
                    best_sel_d   = sel_q;
                end
                if (sel_q == SEL_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SETTLE;
                    sel_d   = sel_q + N'(1);
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end

            // best_sel_q already holds the final winner, because it was
            // updated on the last COMPARE edge.
            ST_DONE: begin
                sel_d   = best_sel_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sel        = sel_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign best_sel   = best_sel_q;
    assign best_score = best_score_q;

endmodule

// File: tb/tb_delay_search_ctrl.sv
// Testbench for delay_search_ctrl.
// The bench models the tap-delay line itself: a shift register of random
// samples, with ref_dly taken from the tap selected by the DUT. The reference
// model replays the logged sample stream against the search schedule to get
// each tap's score. It then picks the winner with plain arithmetic.
module tb_delay_search_ctrl;

    localparam int N      = 4;
    localparam int L      = 16;
    localparam int LOG_W  = 4;
    localparam int SETTLE = 1;
    localparam int W      = 1 << LOG_W;
    localparam int LOGSZ  = 16384;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic                man_load;
    logic [N-1:0]        man_sel;
    logic                sample_en;
    logic [15:0]         ref_dly;
    logic [15:0]         tgt_in;
    logic [N-1:0]        sel;
    logic                busy;
    logic                done;
    logic [N-1:0]        best_sel;
    logic [32+LOG_W-1:0] best_score;

    delay_search_ctrl #(
        .N(N), .L(L), .LOG_W(LOG_W), .SETTLE(SETTLE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .man_load   (man_load),
        .man_sel    (man_sel),
        .sample_en  (sample_en),
        .ref_dly    (ref_dly),
        .tgt_in     (tgt_in),
        .sel        (sel),
        .busy       (busy),
        .done       (done),
        .best_sel   (best_sel),
        .best_score (best_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic signed [15:0] hist [0:31];
    logic signed [15:0] aLog [0:LOGSZ-1];
    bit                 enLog [0:LOGSZ-1];

    bit                 refConstMode;
    bit                 tgtConstMode;
    logic signed [15:0] refConst;
    logic signed [15:0] tgtConst;
    bit                 enToggle;

    typedef struct {
        string   name;
        bit      refConstMode;
        int      refV;
        bit      tgtConstMode;
        int      tgtV;
        bit      enToggle;
        bit      disturb;
        bit      useModel;
        int      expSel;
        longint  expScore;
        int      expEdges;
    } vec_t;

    vec_t vecs [7];

    // The delay line: tap k is the input stream delayed by k cycles. The target
    // is fixed at a delay of 5.
    always_comb begin
        if (refConstMode) ref_dly = refConst;
        else              ref_dly = hist[sel];
    end

    always_comb begin
        if (tgtConstMode) tgt_in = tgtConst;
        else              tgt_in = hist[5];
    end

    // The samples are +-3000 with random sign. Every window then has the same
    // energy, so the tap that matches the target's delay is the strict maximum.
    function automatic logic signed [15:0] newSample();
        if ($urandom_range(0, 1) == 1) return 16'sd3000;
        else                           return -16'sd3000;
    endfunction

    // Advance one clock. Drive the new sample and sample_en 1 time unit after
    // the edge, and log them for the model.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 31; i > 0; i--) hist[i] = hist[i-1];
        hist[0]   = newSample();
        sample_en = enToggle ? ~sample_en : 1'b1;
        if (cyc < LOGSZ) begin
            aLog[cyc]  = hist[0];
            enLog[cyc] = sample_en;
        end
    endtask

    task automatic checkOutput(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model. Start is sampled at the end of cycle c0. Each tap then
    // discards SETTLE enabled samples, correlates the next W enabled samples,
    // and spends one cycle in comparison. The highest score wins, with ties
    // going to the earlier tap.
    function automatic void searchModel(input int c0, output int expSel, output longint expScore);
        int     c;
        int     need;
        int     got;
        longint sum;
        c        = c0 + 1;
        expSel   = 0;
        expScore = 0;
        for (int k = 0; k < L; k++) begin
            need = SETTLE;
            if (need == 0) c++;
            while (need > 0) begin
                if (enLog[c]) need--;
                c++;
            end
            sum = 0;
            got = 0;
            while (got < W) begin
                if (enLog[c]) begin
                    sum += longint'(aLog[c-k]) * longint'(aLog[c-5]);
                    got++;
                end
                c++;
            end
            c++;
            if (k == 0 || sum > expScore) begin
                expScore = sum;
                expSel   = k;
            end
        end
    endfunction

    // Tick until done rises, with a bounded wait. edges counts clock edges, and
    // the edge that samples start counts as edge 1.
    task automatic waitDone(input bit disturb, inout int edges, output bit ok);
        while (!done && edges < 3000) begin
            if (disturb && edges == 100) begin
                start    = 1'b1;
                man_load = 1'b1;
                man_sel  = 4'd9;
            end
            tick();
            edges++;
            start    = 1'b0;
            man_load = 1'b0;
        end
        ok = done;
        checkOutput("done_seen", longint'(done), 1);
    endtask

    // Check the result while done is high. Then check that done and busy both
    // clear on the next edge.
    task automatic applyStimulus(input int expSel, input longint expScore);
        checkOutput("best_sel", longint'(best_sel), longint'(expSel));
        checkOutput("best_score", longint'($signed(best_score)), expScore);
        checkOutput("sel_eq_best", longint'(sel), longint'(expSel));
        checkOutput("busy_low_at_done", longint'(busy), 0);
        tick();
        checkOutput("done_clears", longint'(done), 0);
        checkOutput("busy_clears", longint'(busy), 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_sel"}, longint'(sel), 0);
        checkOutput({tag, "_busy"}, longint'(busy), 0);
        checkOutput({tag, "_done"}, longint'(done), 0);
        checkOutput({tag, "_best_sel"}, longint'(best_sel), 0);
        checkOutput({tag, "_best_score"}, longint'($signed(best_score)), 0);
    endtask

    initial begin
        int     c0;
        int     edges;
        bit     ok;
        int     mSel;
        longint mScore;
        int     lastSel;
        longint lastScore;
        int     r;
        int     t;

        r = int'($urandom_range(0, 4000)) - 2000;
        t = int'($urandom_range(0, 4000)) - 2000;

        vecs[0] = '{"lfsr_d5",     0, 0,    0, 0,     0, 0, 1, 0, 0,           290};
        vecs[1] = '{"tgt_zero",    0, 0,    1, 0,     0, 0, 0, 0, 0,           290};
        vecs[2] = '{"neg_const",   1, 1000, 1, -1000, 0, 0, 0, 0, -16000000,   290};
        vecs[3] = '{"disturb",     0, 0,    0, 0,     0, 1, 1, 0, 0,           290};
        vecs[4] = '{"en_toggle",   0, 0,    0, 0,     1, 0, 1, 0, 0,           0};
        vecs[5] = '{"rand_const",  1, r,    1, t,     0, 0, 0, 0, 16 * longint'(r) * longint'(t), 290};
        vecs[6] = '{"pos_const",   1, 1000, 1, 1000,  0, 0, 0, 0, 16000000,    290};

        for (int i = 0; i < 32; i++) hist[i] = newSample();
        refConstMode = 1'b0;
        tgtConstMode = 1'b0;
        refConst     = '0;
        tgtConst     = '0;
        enToggle     = 1'b0;
        start        = 1'b0;
        man_load     = 1'b0;
        man_sel      = '0;
        sample_en    = 1'b1;
        rst_n        = 1'b0;

        // Hold reset while the stream runs, then release with no start.
        for (int i = 0; i < 40; i++) tick();
        checkResetOutputs("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checkResetOutputs("post_reset_idle");

        lastSel   = 0;
        lastScore = 0;
        foreach (vecs[v]) begin
            refConstMode = vecs[v].refConstMode;
            refConst     = 16'(vecs[v].refV);
            tgtConstMode = vecs[v].tgtConstMode;
            tgtConst     = 16'(vecs[v].tgtV);
            enToggle     = vecs[v].enToggle;
            tick();
            tick();

            start = 1'b1;
            c0    = cyc;
            tick();
            start = 1'b0;
            edges = 1;
            checkOutput({vecs[v].name, "_busy_after_start"}, longint'(busy), 1);
            waitDone(vecs[v].disturb, edges, ok);
            if (vecs[v].expEdges != 0)
                checkOutput({vecs[v].name, "_latency"}, longint'(edges), longint'(vecs[v].expEdges));

            if (vecs[v].useModel) begin
                searchModel(c0, mSel, mScore);
            end else begin
                mSel   = vecs[v].expSel;
                mScore = vecs[v].expScore;
            end
            if (vecs[v].useModel)
                checkOutput({vecs[v].name, "_score_positive"}, longint'($signed(best_score) > 0), 1);
            applyStimulus(mSel, mScore);
            lastSel   = mSel;
            lastScore = mScore;
        end

        // Manual load in IDLE.
        refConstMode = 1'b0;
        tgtConstMode = 1'b0;
        enToggle     = 1'b0;
        man_sel      = 4'd9;
        man_load     = 1'b1;
        tick();
        man_load = 1'b0;
        checkOutput("man_load_sel", longint'(sel), 9);
        checkOutput("man_load_busy", longint'(busy), 0);

        // start and man_load together: start wins. The previous best must be
        // held until candidate 0 is compared.
        start    = 1'b1;
        man_load = 1'b1;
        man_sel  = 4'd9;
        c0       = cyc;
        tick();
        start    = 1'b0;
        man_load = 1'b0;
        edges    = 1;
        checkOutput("start_wins_busy", longint'(busy), 1);
        checkOutput("start_wins_sel", longint'(sel), 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            edges++;
        end
        checkOutput("best_sel_held", longint'(best_sel), longint'(lastSel));
        checkOutput("best_score_held", longint'($signed(best_score)), lastScore);
        waitDone(1'b0, edges, ok);
        checkOutput("start_wins_latency", longint'(edges), 290);
        searchModel(c0, mSel, mScore);
        applyStimulus(mSel, mScore);

        // Abort with reset while candidate 8 is active.
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 0;
        while (sel != 4'd8 && edges < 1000) begin
            tick();
            edges++;
        end
        checkOutput("reached_cand8", longint'(sel), 8);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("abort");
        tick();
        tick();
        checkResetOutputs("abort_hold");
        rst_n = 1'b1;
        tick();
        checkResetOutputs("abort_release");

        // A new search after the abort completes normally.
        start = 1'b1;
        c0    = cyc;
        tick();
        start = 1'b0;
        edges = 1;
        checkOutput("restart_busy", longint'(busy), 1);
        waitDone(1'b0, edges, ok);
        checkOutput("restart_latency", longint'(edges), 290);
        searchModel(c0, mSel, mScore);
        applyStimulus(mSel, mScore);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
